// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined RISC-V core: issues loads/stores over a req/ack port,
// resolves branch pc_src, and registers the MEM/WB bundle while stalling upstream during accesses.
module mem_access_stage #(
    parameter int CONTROL_LINE     = 5,
    parameter int DATA_LEN         = 64,
    parameter int INSTRUCTION_PART = 5,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [CONTROL_LINE-1:0]     control_in,
    input  logic                        zero_in,
    input  logic [DATA_LEN-1:0]         alu_val,
    input  logic [DATA_LEN-1:0]         wr_addr,
    input  logic [INSTRUCTION_PART-1:0] instruction_part,
    output logic                        stall,
    output logic                        pc_src,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [DATA_LEN-1:0]         dmem_addr,
    output logic [DATA_LEN-1:0]         dmem_wdata,
    input  logic                        dmem_ack,
    input  logic [DATA_LEN-1:0]         dmem_rdata,
    output logic                        wb_valid,
    output logic                        wb_reg_write,
    output logic                        wb_mem_to_reg,
    output logic [INSTRUCTION_PART-1:0] wb_rd,
    output logic [DATA_LEN-1:0]         wb_alu_val,
    output logic [DATA_LEN-1:0]         wb_mem_data,
    output logic                        mem_err,
    output logic [0:0]                  dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    // Handshake: dmem_req stays high with stable we/addr/wdata until the cycle dmem_ack is seen;
    // dmem_rdata is only sampled in that ack cycle, and acks outside a request are ignored.

    logic [0:0]                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        h_we_q, h_we_d;
    logic [DATA_LEN-1:0]         h_addr_q, h_addr_d;
    logic [DATA_LEN-1:0]         h_wdata_q, h_wdata_d;
    logic                        h_reg_write_q, h_reg_write_d;
    logic                        h_mem_to_reg_q, h_mem_to_reg_d;
    logic [INSTRUCTION_PART-1:0] h_rd_q, h_rd_d;
    logic                        wb_valid_q, wb_valid_d;
    logic                        wb_reg_write_q, wb_reg_write_d;
    logic                        wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [INSTRUCTION_PART-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_LEN-1:0]         wb_alu_val_q, wb_alu_val_d;
    logic [DATA_LEN-1:0]         wb_mem_data_q, wb_mem_data_d;
    logic                        err_q, err_d;

    logic is_mem;
    logic aligned;

    assign is_mem  = control_in[0] | control_in[1];
    assign aligned = (alu_val[2:0] == 3'b000);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        h_we_d          = h_we_q;
        h_addr_d        = h_addr_q;
        h_wdata_d       = h_wdata_q;
        h_reg_write_d   = h_reg_write_q;
        h_mem_to_reg_d  = h_mem_to_reg_q;
        h_rd_d          = h_rd_q;
        wb_valid_d      = 1'b0;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_rd_d         = wb_rd_q;
        wb_alu_val_d    = wb_alu_val_q;
        wb_mem_data_d   = wb_mem_data_q;
        err_d           = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d      = 1'b1;
                        wb_reg_write_d  = control_in[2];
                        wb_mem_to_reg_d = control_in[3];
                        wb_rd_d         = instruction_part;
                        wb_alu_val_d    = alu_val;
                        wb_mem_data_d   = '0;
                    end else if (!aligned) begin
                        // Misaligned access never reaches memory; retire it without a register write.
                        err_d           = 1'b1;
                        wb_valid_d      = 1'b1;
                        wb_reg_write_d  = 1'b0;
                        wb_mem_to_reg_d = control_in[3];
                        wb_rd_d         = instruction_part;
                        wb_alu_val_d    = alu_val;
                        wb_mem_data_d   = '0;
                    end else begin
                        state_d        = ST_REQ;
                        cnt_d          = '0;
                        h_we_d         = control_in[1];
                        h_addr_d       = alu_val;
                        h_wdata_d      = wr_addr;
                        h_reg_write_d  = control_in[2];
                        h_mem_to_reg_d = control_in[3];
                        h_rd_d         = instruction_part;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    state_d         = ST_IDLE;
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = h_reg_write_q;
                    wb_mem_to_reg_d = h_mem_to_reg_q;
                    wb_rd_d         = h_rd_q;
                    wb_alu_val_d    = h_addr_q;
                    wb_mem_data_d   = h_we_q ? '0 : dmem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = ST_IDLE;
                    err_d           = 1'b1;
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = 1'b0;
                    wb_mem_to_reg_d = h_mem_to_reg_q;
                    wb_rd_d         = h_rd_q;
                    wb_alu_val_d    = h_addr_q;
                    wb_mem_data_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            h_we_q          <= 1'b0;
            h_addr_q        <= '0;
            h_wdata_q       <= '0;
            h_reg_write_q   <= 1'b0;
            h_mem_to_reg_q  <= 1'b0;
            h_rd_q          <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_alu_val_q    <= '0;
            wb_mem_data_q   <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            h_we_q          <= h_we_d;
            h_addr_q        <= h_addr_d;
            h_wdata_q       <= h_wdata_d;
            h_reg_write_q   <= h_reg_write_d;
            h_mem_to_reg_q  <= h_mem_to_reg_d;
            h_rd_q          <= h_rd_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_rd_q         <= wb_rd_d;
            wb_alu_val_q    <= wb_alu_val_d;
            wb_mem_data_q   <= wb_mem_data_d;
            err_q           <= err_d;
        end
    end

    assign stall         = (state_q == ST_REQ);
    assign dmem_req      = (state_q == ST_REQ);
    assign dmem_we       = h_we_q;
    assign dmem_addr     = h_addr_q;
    assign dmem_wdata    = h_wdata_q;
    assign pc_src        = in_valid & control_in[4] & zero_in & (state_q == ST_IDLE);
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_rd         = wb_rd_q;
    assign wb_alu_val    = wb_alu_val_q;
    assign wb_mem_data   = wb_mem_data_q;
    assign mem_err       = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model predicts outputs each cycle,
// plus literal spot checks of the scenarios the stage must handle.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  control_in;
    logic        zero_in;
    logic [63:0] alu_val;
    logic [63:0] wr_addr;
    logic [4:0]  instruction_part;
    logic        stall;
    logic        pc_src;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [63:0] wb_alu_val;
    logic [63:0] wb_mem_data;
    logic        mem_err;
    logic [0:0]  dbg_state;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .control_in(control_in),
        .zero_in(zero_in), .alu_val(alu_val), .wr_addr(wr_addr),
        .instruction_part(instruction_part), .stall(stall), .pc_src(pc_src),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd(wb_rd), .wb_alu_val(wb_alu_val), .wb_mem_data(wb_mem_data),
        .mem_err(mem_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    bit chk_en;

    // model: one pending memory transaction plus the expected MEM/WB record
    bit          m_busy;
    int          m_age;
    bit          p_we;
    logic [63:0] p_addr, p_wdata;
    bit          p_rw, p_m2r;
    logic [4:0]  p_rd;
    bit          e_valid, e_rw, e_m2r, e_err, e_partial;
    logic [4:0]  e_rd;
    logic [63:0] e_alu, e_md;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0;
        p_we = 0; p_addr = '0; p_wdata = '0; p_rw = 0; p_m2r = 0; p_rd = '0;
        e_valid = 0; e_rw = 0; e_m2r = 0; e_err = 0; e_partial = 0;
        e_rd = '0; e_alu = '0; e_md = '0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            e_valid = 0;
            if (in_valid) begin
                if (!(control_in[0] || control_in[1])) begin
                    e_valid = 1; e_rw = control_in[2]; e_m2r = control_in[3];
                    e_rd = instruction_part; e_alu = alu_val; e_md = '0; e_partial = 0;
                end else if (alu_val % 8 != 0) begin
                    e_err = 1; e_valid = 1; e_rw = 0; e_partial = 1;
                end else begin
                    m_busy = 1; m_age = 0;
                    p_we = control_in[1]; p_addr = alu_val; p_wdata = wr_addr;
                    p_rw = control_in[2]; p_m2r = control_in[3]; p_rd = instruction_part;
                end
            end
        end else begin
            m_age++;
            e_valid = 0;
            if (dmem_ack) begin
                m_busy = 0; e_valid = 1; e_rw = p_rw; e_m2r = p_m2r; e_rd = p_rd;
                e_alu = p_addr; e_md = p_we ? 64'h0 : dmem_rdata; e_partial = 0;
            end else if (m_age == 16) begin
                m_busy = 0; e_err = 1; e_valid = 1; e_rw = 0; e_partial = 1;
            end
        end
    endtask

    // compare process body: every cycle, DUT outputs against the model
    task automatic check_outputs();
        chk("stall", stall, m_busy);
        chk("pc_src", pc_src, in_valid & control_in[4] & zero_in & !m_busy);
        chk("dmem_req", dmem_req, m_busy);
        if (m_busy) begin
            chk("dmem_we", dmem_we, p_we);
            chk("dmem_addr", dmem_addr, p_addr);
            chk("dmem_wdata", dmem_wdata, p_wdata);
        end
        chk("wb_valid", wb_valid, e_valid);
        chk("mem_err", mem_err, e_err);
        chk("wb_reg_write", wb_reg_write, e_rw);
        if (!e_partial) begin
            chk("wb_mem_to_reg", wb_mem_to_reg, e_m2r);
            chk("wb_rd", wb_rd, e_rd);
            chk("wb_alu_val", wb_alu_val, e_alu);
            chk("wb_mem_data", wb_mem_data, e_md);
        end
    endtask

    task automatic tick();
        #1;
        if (chk_en) check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver tasks
    task automatic set_in(input bit v, input logic [4:0] c, input bit z,
                          input logic [63:0] a, input logic [63:0] w, input logic [4:0] r);
        in_valid = v; control_in = c; zero_in = z; alu_val = a; wr_addr = w; instruction_part = r;
    endtask

    task automatic set_mem(input bit ack, input logic [63:0] rd);
        dmem_ack = ack; dmem_rdata = rd;
    endtask

    task automatic idle();
        set_in(0, 5'b00000, 0, 64'h0, 64'h0, 5'd0);
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 0;
        model_reset();
        rst = 1; idle(); set_mem(0, 64'h0);
        @(negedge clk);
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_stall", stall, 1'b0);

        // ALU op, then a stray ack while idle
        set_in(1, 5'b00100, 0, 64'hDEAD, 64'h0, 5'd7);
        tick();
        idle(); set_mem(1, 64'hFFFF);
        chk("alu_wb_valid", wb_valid, 1'b1);
        chk("alu_wb_alu_val", wb_alu_val, 64'hDEAD);
        chk("alu_wb_rd", wb_rd, 5'd7);
        chk("alu_stall", stall, 1'b0);
        tick();
        set_mem(0, 64'h0);

        // load acked in third REQ cycle; new upstream input ignored while stalled
        set_in(1, 5'b01101, 0, 64'h100, 64'h0, 5'd3);
        tick();
        set_in(1, 5'b10100, 1, 64'hBEEF, 64'h0, 5'd9);
        chk("ld_req", dmem_req, 1'b1);
        chk("ld_addr", dmem_addr, 64'h100);
        chk("ld_we", dmem_we, 1'b0);
        chk("ld_stall", stall, 1'b1);
        tick();
        tick();
        set_mem(1, 64'h0123_4567_89AB_CDEF);
        tick();
        set_mem(0, 64'h0); idle();
        chk("ld_wb_valid", wb_valid, 1'b1);
        chk("ld_wb_mem_data", wb_mem_data, 64'h0123_4567_89AB_CDEF);
        chk("ld_wb_rd", wb_rd, 5'd3);
        tick();

        // store acked in first REQ cycle
        set_in(1, 5'b00010, 0, 64'h208, 64'h55AA, 5'd4);
        tick();
        idle(); set_mem(1, 64'hAAAA);
        chk("st_we", dmem_we, 1'b1);
        chk("st_wdata", dmem_wdata, 64'h55AA);
        tick();
        set_mem(0, 64'h0);
        chk("st_wb_valid", wb_valid, 1'b1);
        chk("st_wb_reg_write", wb_reg_write, 1'b0);
        chk("st_wb_mem_data", wb_mem_data, 64'h0);
        tick();

        // MemRead and MemWrite together act as a store
        set_in(1, 5'b00111, 0, 64'h10, 64'h77, 5'd5);
        tick();
        idle(); set_mem(1, 64'h99);
        chk("rw_we", dmem_we, 1'b1);
        tick();
        set_mem(0, 64'h0);
        chk("rw_wb_mem_data", wb_mem_data, 64'h0);
        tick();

        // ack in the 16th REQ cycle completes normally
        set_in(1, 5'b01101, 0, 64'h300, 64'h0, 5'd6);
        tick();
        idle();
        for (int i = 0; i < 15; i++) tick();
        set_mem(1, 64'hCAFE);
        tick();
        set_mem(0, 64'h0);
        chk("ack16_wb_valid", wb_valid, 1'b1);
        chk("ack16_mem_err", mem_err, 1'b0);
        chk("ack16_wb_mem_data", wb_mem_data, 64'hCAFE);
        tick();

        // no ack: abort after 16 REQ cycles
        set_in(1, 5'b01101, 0, 64'h400, 64'h0, 5'd8);
        tick();
        idle();
        for (int i = 0; i < 16; i++) tick();
        chk("to_wb_valid", wb_valid, 1'b1);
        chk("to_mem_err", mem_err, 1'b1);
        chk("to_wb_reg_write", wb_reg_write, 1'b0);
        chk("to_stall", stall, 1'b0);
        tick();

        // reset clears the sticky error
        rst = 1;
        tick();
        rst = 0;
        chk("rst2_mem_err", mem_err, 1'b0);

        // misaligned load
        set_in(1, 5'b01101, 0, 64'h103, 64'h0, 5'd2);
        tick();
        idle();
        chk("mis_mem_err", mem_err, 1'b1);
        chk("mis_req", dmem_req, 1'b0);
        chk("mis_wb_reg_write", wb_reg_write, 1'b0);
        tick();

        // branch taken / not taken
        set_in(1, 5'b10000, 1, 64'h0, 64'h0, 5'd0);
        #1 chk("br_taken", pc_src, 1'b1);
        tick();
        set_in(1, 5'b10000, 0, 64'h0, 64'h0, 5'd0);
        #1 chk("br_not_taken", pc_src, 1'b0);
        tick();
        idle();

        // reset during the second REQ cycle
        set_in(1, 5'b01101, 0, 64'h500, 64'h0, 5'd1);
        tick();
        idle();
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rmid_req", dmem_req, 1'b0);
        chk("rmid_stall", stall, 1'b0);
        chk("rmid_wb_valid", wb_valid, 1'b0);
        chk("rmid_mem_err", mem_err, 1'b0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
